// File: rtl/biriscv_decode_fifo_pkg.sv
// Shared fetch-entry definitions for the fetch-to-decode instruction buffer.
// Fault encoding: fault_fetch = bus error, fault_page = page fault; either one voids the opcode.
package biriscv_decode_fifo_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;
   localparam int ENTRY_W = INSTR_W + PC_W + 2;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
      logic               fault_fetch;
      logic               fault_page;
   } fifo_entry_t;

   function automatic logic [INSTR_W-1:0] masked_instr(input fifo_entry_t e);
      return (e.fault_fetch | e.fault_page) ? '0 : e.instr;
   endfunction

endpackage

// File: rtl/biriscv_decode_fifo.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO with valid/accept handshakes
// and single-cycle flush on branch redirect.
module biriscv_decode_fifo
   import biriscv_decode_fifo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fetch_valid_i,
   input  logic [31:0]              fetch_instr_i,
   input  logic [31:0]              fetch_pc_i,
   input  logic                     fetch_fault_fetch_i,
   input  logic                     fetch_fault_page_i,
   output logic                     fetch_accept_o,
   input  logic                     branch_request_i,
   output logic                     decode_valid_o,
   output logic [31:0]              decode_instr_o,
   output logic [31:0]              decode_pc_o,
   output logic                     decode_fault_fetch_o,
   output logic                     decode_fault_page_o,
   input  logic                     decode_accept_i,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] count;
   logic             push;
   logic             pop;
   fifo_entry_t      entry_in;
   fifo_entry_t      head;

   assign fetch_accept_o = (count != LVL_W'(DEPTH));
   assign decode_valid_o = (count != '0);
   assign level_o        = count;

   assign push = fetch_valid_i & fetch_accept_o & ~branch_request_i;
   assign pop  = decode_valid_o & decode_accept_i & ~branch_request_i;

   assign entry_in = '{instr:       fetch_instr_i,
                       pc:          fetch_pc_i,
                       fault_fetch: fetch_fault_fetch_i,
                       fault_page:  fetch_fault_page_i};

   // Pointers wrap for free because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i || branch_request_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is never cleared; stale entries are hidden by count.
   always_ff @(posedge clk_i) begin
      if (push && !rst_i)
         mem[wr_ptr] <= entry_in;
   end

   assign head                 = mem[rd_ptr];
   assign decode_instr_o       = masked_instr(head);
   assign decode_pc_o          = head.pc;
   assign decode_fault_fetch_o = head.fault_fetch;
   assign decode_fault_page_o  = head.fault_page;

   depth_pow2 : assert property (@(posedge clk_i) ((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0)));

endmodule

// File: tb/tb_biriscv_decode_fifo.sv
// Bench for biriscv_decode_fifo: directed plan steps plus random traffic against a queue model.
module tb_biriscv_decode_fifo;
   import biriscv_decode_fifo_pkg::*;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        fv;
   logic [31:0] finstr;
   logic [31:0] fpc;
   logic        ffetch;
   logic        fpage;
   logic        faccept;
   logic        br;
   logic        dvalid;
   logic [31:0] dinstr;
   logic [31:0] dpc;
   logic        dffetch;
   logic        dfpage;
   logic        daccept;
   logic [2:0]  level;

   int checks;
   int failures;

   fifo_entry_t model_q[$];

   biriscv_decode_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .fetch_valid_i       (fv),
      .fetch_instr_i       (finstr),
      .fetch_pc_i          (fpc),
      .fetch_fault_fetch_i (ffetch),
      .fetch_fault_page_i  (fpage),
      .fetch_accept_o      (faccept),
      .branch_request_i    (br),
      .decode_valid_o      (dvalid),
      .decode_instr_o      (dinstr),
      .decode_pc_o         (dpc),
      .decode_fault_fetch_o(dffetch),
      .decode_fault_page_o (dfpage),
      .decode_accept_i     (daccept),
      .level_o             (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare all visible outputs with the queue model (called at negedge).
   task automatic check_outputs(input string tag);
      int n;
      n = model_q.size();
      chk({tag, ".level"},  32'(level),   32'(n));
      chk({tag, ".accept"}, 32'(faccept), 32'(n < DEPTH));
      chk({tag, ".valid"},  32'(dvalid),  32'(n > 0));
      if (n > 0) begin
         chk({tag, ".pc"},     dpc, model_q[0].pc);
         chk({tag, ".instr"},  dinstr,
             (model_q[0].fault_fetch || model_q[0].fault_page) ? 32'h0 : model_q[0].instr);
         chk({tag, ".ffetch"}, 32'(dffetch), 32'(model_q[0].fault_fetch));
         chk({tag, ".fpage"},  32'(dfpage),  32'(model_q[0].fault_page));
      end
   endtask

   // One clock: check outputs, drive inputs, advance model, wait to next negedge.
   task automatic cycle(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ff, input logic fp, input logic dacc, input logic b, input logic r);
      bit can_push;
      bit can_pop;
      fifo_entry_t e;
      check_outputs(tag);
      fv = v; finstr = ins; fpc = pc; ffetch = ff; fpage = fp;
      daccept = dacc; br = b; rst = r;
      can_push = (model_q.size() < DEPTH);
      can_pop  = (model_q.size() > 0);
      e.instr = ins; e.pc = pc; e.fault_fetch = ff; e.fault_page = fp;
      @(posedge clk);
      if (r || b) begin
         model_q.delete();
      end else begin
         if (dacc && can_pop) void'(model_q.pop_front());
         if (v && can_push) model_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      cycle(tag, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      fv = 0; finstr = 0; fpc = 0; ffetch = 0; fpage = 0;
      daccept = 0; br = 0; rst = 1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 0;

      // Single push, no accept: visible one cycle later.
      cycle("push1", 1, 32'h00000013, 32'h80000000, 0, 0, 0, 0, 0);
      idle("push1_vis");

      // Fill to DEPTH, try a 5th push, then pop once while fetch still tries.
      for (int i = 1; i < 4; i++)
         cycle("fill", 1, 32'h1000 + 32'(i), 32'h80000000 + 32'(4 * i), 0, 0, 0, 0, 0);
      cycle("push5", 1, 32'hdeadbeef, 32'h90000000, 0, 0, 0, 0, 0);
      cycle("pop_full", 1, 32'hcafef00d, 32'h90000004, 0, 0, 1, 0, 0);
      idle("after_pop");

      // Flush, then streamed push+pop across the pointer wrap.
      cycle("flush_full", 0, 0, 0, 0, 0, 0, 1, 0);
      cycle("stream0", 1, 32'h00a00093, 32'h100, 0, 0, 1, 0, 0);
      for (int i = 1; i < 10; i++)
         cycle("stream", 1, 32'h00a00093 + 32'(i), 32'h100 + 32'(4 * i), 0, 0, 1, 0, 0);
      cycle("drain", 0, 0, 0, 0, 0, 1, 0, 0);

      // Faulted entries: instruction forced to zero.
      cycle("fpage", 1, 32'h12345678, 32'h2000, 0, 1, 0, 0, 0);
      cycle("ffetch", 1, 32'h87654321, 32'h2004, 1, 0, 1, 0, 0);
      cycle("fault_pop", 0, 0, 0, 0, 0, 1, 0, 0);
      idle("fault_empty");

      // Flush with concurrent push and pop while 3 entries are held.
      for (int i = 0; i < 3; i++)
         cycle("hold3", 1, 32'h3000 + 32'(i), 32'h3000 + 32'(4 * i), 0, 0, 0, 0, 0);
      cycle("br_pushpop", 1, 32'h3333, 32'h300c, 0, 0, 1, 1, 0);
      cycle("post_br_push", 1, 32'h4444, 32'h4000, 0, 0, 0, 0, 0);
      idle("post_br_head");

      // Reset with 2 held and a push active.
      cycle("hold2", 1, 32'h5000, 32'h5000, 0, 0, 0, 0, 0);
      cycle("rst_push", 1, 32'h5555, 32'h5004, 0, 0, 0, 0, 1);
      idle("post_rst");

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
               1'($urandom_range(0, 99) == 0));
      end
      idle("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
